// File: rtl/key_pkg.sv
// ----------------------------------------------------------------------------
// key_pkg
// Shared state and event encodings for the key click decoder.
// Optional feature macro: KEY_CLICK_TRIPLE_EN (adds state TWO / triple clicks)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package key_pkg;

   // Decoder state encoding; TWO only exists when triple clicks are decoded
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONE  = 2'd1
`ifdef KEY_CLICK_TRIPLE_EN
      ,
      TWO  = 2'd2
`endif
   } key_state_t;

   // Event codes reported on last_event
   localparam logic [1:0] EV_NONE   = 2'd0;
   localparam logic [1:0] EV_SINGLE = 2'd1;
   localparam logic [1:0] EV_DOUBLE = 2'd2;
   localparam logic [1:0] EV_TRIPLE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/click_window_timer.sv
// ----------------------------------------------------------------------------
// click_window_timer
// Inter-click window counter: cleared on each accepted press, counts while
// enabled and saturates at the terminal value, flagged on o_term.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module click_window_timer #(
   parameter int              CNT_W = 24,
   parameter logic [CNT_W-1:0] LAST  = '1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_term
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_term;

   assign w_term = (r_cnt == LAST);
   assign o_term = w_term;

   // Window count: clear wins, otherwise count up until the terminal value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_term) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/key_click_decoder.sv
// ----------------------------------------------------------------------------
// key_click_decoder
// Groups debounced key press pulses into single/double(/triple) click events,
// reported as a registered one-cycle strobe plus a held event code.
// Optional feature macro: KEY_CLICK_TRIPLE_EN (enables triple-click decoding;
// when undefined the second press decodes a double click immediately).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module key_click_decoder
   import key_pkg::*;
#(
   parameter int FREQ      = 50,
   parameter int WINDOW_MS = 300,
   parameter int CNT_W     = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_pulse,
   output logic       single_click,
   output logic       double_click,
   output logic       triple_click,
   output logic       busy,
   output logic [1:0] last_event
);

   localparam int               WINDOW_CYCLES = WINDOW_MS * 1000 * FREQ;
   localparam logic [CNT_W-1:0] C_LAST        = CNT_W'(WINDOW_CYCLES - 1);

   key_state_t r_state;
   key_state_t w_state_n;
   logic       r_single;
   logic       r_double;
   logic       w_single_n;
   logic       w_double_n;
   logic       w_triple_n;
   logic [1:0] r_last_event;
   logic [1:0] w_last_event_n;
   logic       w_clr;
   logic       w_en;
   logic       w_term;
   logic       w_expire;

   // A press in the terminal cycle wins over expiry and restarts the window
   assign w_expire = w_term && !key_pulse;
   assign w_en     = (r_state != IDLE);

   click_window_timer #(
      .CNT_W (CNT_W),
      .LAST  (C_LAST)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .o_term (w_term)
   );

   // Next-state, strobe and event-code decode
   always_comb begin
      w_state_n      = r_state;
      w_single_n     = 1'b0;
      w_double_n     = 1'b0;
      w_triple_n     = 1'b0;
      w_last_event_n = r_last_event;
      w_clr          = 1'b0;
      case (r_state)
         IDLE: begin
            if (key_pulse) begin
               w_state_n = ONE;
               w_clr     = 1'b1;
            end
         end
         ONE: begin
            if (key_pulse) begin
`ifdef KEY_CLICK_TRIPLE_EN
               w_state_n = TWO;
               w_clr     = 1'b1;
`else
               w_state_n      = IDLE;
               w_double_n     = 1'b1;
               w_last_event_n = EV_DOUBLE;
`endif
            end else if (w_expire) begin
               w_state_n      = IDLE;
               w_single_n     = 1'b1;
               w_last_event_n = EV_SINGLE;
            end
         end
`ifdef KEY_CLICK_TRIPLE_EN
         TWO: begin
            if (key_pulse) begin
               w_state_n      = IDLE;
               w_triple_n     = 1'b1;
               w_last_event_n = EV_TRIPLE;
            end else if (w_expire) begin
               w_state_n      = IDLE;
               w_double_n     = 1'b1;
               w_last_event_n = EV_DOUBLE;
            end
         end
`endif
         default: begin
            w_state_n = IDLE;
         end
      endcase
   end

   // State, strobe and event-code registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_single     <= 1'b0;
         r_double     <= 1'b0;
         r_last_event <= EV_NONE;
      end else begin
         r_state      <= w_state_n;
         r_single     <= w_single_n;
         r_double     <= w_double_n;
         r_last_event <= w_last_event_n;
      end
   end

`ifdef KEY_CLICK_TRIPLE_EN
   logic r_triple;

   // Triple strobe register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_triple <= 1'b0;
      end else begin
         r_triple <= w_triple_n;
      end
   end

   assign triple_click = r_triple;
`else
   logic w_triple_unused;
   assign w_triple_unused = w_triple_n;
   assign triple_click    = 1'b0;
`endif

   assign single_click = r_single;
   assign double_click = r_double;
   assign busy         = (r_state != IDLE);
   assign last_event   = r_last_event;

endmodule

`default_nettype wire

// File: doc/key_click_decoder.md
# key_click_decoder

Classifies the one-cycle key press pulses from the key debounce stage into single, double and triple clicks. Presses separated by no more than a programmable inter-click window are grouped into one event. Each decoded event is reported as a one-cycle strobe plus a held event code. The block sits directly downstream of the debouncer's negative-edge pulse output and feeds the control logic that needs multi-function buttons.

## Interface
- FREQ, 50: clock frequency in MHz.
- WINDOW_MS, 300: maximum gap between consecutive presses of one event, in ms.
- CNT_W, 24: window counter width; must hold WINDOW_CYCLES-1, where WINDOW_CYCLES = WINDOW_MS*1000*FREQ.

- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- key_pulse  input  1  one-cycle press strobe, synchronous to clk (debouncer negedge output).
- single_click  output  1  one-cycle strobe: event was one press.
- double_click  output  1  one-cycle strobe: event was two presses.
- triple_click  output  1  one-cycle strobe: event was three presses (tied 0 when feature disabled).
- busy  output  1  high while an event is being collected (state not IDLE).
- last_event  output  2  code of the most recent event: 0 none, 1 single, 2 double, 3 triple; held until the next event.

## Operation
- States: IDLE, ONE (one press seen), TWO (two presses seen).
- Window counter cnt is cleared to 0 on every accepted pulse and increments each cycle in ONE or TWO.
- Expiry condition: cnt == WINDOW_CYCLES-1 with key_pulse low.
- IDLE: key_pulse -> ONE, cnt=0; otherwise stay.
- ONE: key_pulse -> TWO, cnt=0; expiry -> IDLE, single_click=1, last_event=1.
- TWO, feature enabled: key_pulse -> IDLE, triple_click=1, last_event=3 (immediate, no wait); expiry -> IDLE, double_click=1, last_event=2.
- TWO, feature disabled: not reachable. In ONE, key_pulse -> IDLE, double_click=1, last_event=2 (immediate).
- Simultaneous key_pulse and cnt == WINDOW_CYCLES-1: the pulse wins; it counts as a click and the window restarts.
- At most one strobe is high in any cycle. Strobes are registered and last one cycle.
- key_pulse in the cycle a strobe is issued is seen in IDLE and starts a new event (state ONE on the next cycle).
- cnt never wraps: it stops at WINDOW_CYCLES-1 because expiry leaves the state.

## Timing
- Reset values: state IDLE, cnt 0, single_click/double_click/triple_click 0, busy 0, last_event 0.
- Reset mid-event: the event is discarded and no strobe is issued.
- Pulse in cycle t from IDLE: busy high from cycle t+1.
- Single click, pulse at cycle t: single_click high in cycle t+WINDOW_CYCLES+1; busy low in the same cycle.
- Second press at cycle t2: double_click (expired case) high at t2+WINDOW_CYCLES+1.
- Immediate strobe (triple_click, or double_click when disabled): high in cycle t3+1 for a pulse at cycle t3.
- last_event updates on the same edge as its strobe.

## Configuration
- KEY_CLICK_TRIPLE_EN defined: state TWO exists and triple detection works as above.
- KEY_CLICK_TRIPLE_EN undefined: the FSM has only IDLE and ONE, the second press decodes double immediately, triple_click is constant 0, and last_event never equals 3.

## Structure
- Shared package (key_pkg) holds:
  - state encoding constants: IDLE=0, ONE=1, TWO=2.
  - event code constants: EV_NONE=0, EV_SINGLE=1, EV_DOUBLE=2, EV_TRIPLE=3.
- One sub-module, click_window_timer, holds the CNT_W counter with clear, enable and terminal-flag outputs. The FSM and output registers live in key_click_decoder.

## Test plan
Bench with FREQ=1, WINDOW_MS=1 (WINDOW_CYCLES=1000).
- Single press at cycle 10 -> single_click high only in cycle 1011, last_event=1, busy high cycles 11–1010.
- Two pulses at cycles 10 and 500, feature enabled -> double_click in cycle 1501, last_event=2; no single_click.
- Three pulses at cycles 10/400/800, feature enabled -> triple_click in cycle 801, busy low at 801; same stimulus disabled -> double_click at 401, then single_click at 1801.
- Pulse exactly at cnt==999 (pulses at 10 and 1010) -> no single_click; treated as double; double_click at 2011.
- Pulses at 10 and 1011 (gap > window) -> single_click at 1011, and the second pulse starts a new event; single_click again at 2012.
- rst asserted at cycle 600 after a pulse at 10 -> outputs 0 immediately, no strobe after release, last_event=0.
